multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 129 ++++++++++++
 tb/tb_multicycle_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, shifts done one bit per
// cycle, registered result with done pulse and held status flags.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, work;
  logic [3:0]       op_q;
  logic [4:0]       count;
  logic [WIDTH-1:0] sum, diff, exec_result;
  logic             exec_ovf, exec_illegal;
  logic             is_shift;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign is_shift = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
  assign sum      = a_q + b_q;
  assign diff     = a_q - b_q;

  always_comb begin
    exec_result  = '0;
    exec_ovf     = 1'b0;
    exec_illegal = 1'b0;
    case (op_q)
      OP_AND: exec_result = a_q & b_q;
      OP_OR:  exec_result = a_q | b_q;
      OP_NOR: exec_result = ~(a_q | b_q);
      OP_ADD: begin
        exec_result = sum;
        exec_ovf    = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        exec_result = diff;
        exec_ovf    = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      // Shifts are routed through SHIFT and never reach EXEC.
      OP_SLL, OP_SRL: exec_result = b_q;
      OP_LUI: exec_result = b_q << 16;
      default: exec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = is_shift ? SHIFT : EXEC;
      EXEC:    state_next = DONE;
      SHIFT:   if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      work      <= '0;
      op_q      <= '0;
      count     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= A;
          b_q   <= B;
          work  <= B;
          op_q  <= ALUOperation;
          count <= shamt;
        end
        EXEC: begin
          ALUResult <= exec_result;
          Zero      <= (exec_result == '0);
          Overflow  <= exec_ovf;
          Illegal   <= exec_illegal;
        end
        SHIFT: begin
          if (count == '0) begin
            ALUResult <= work;
            Zero      <= (work == '0);
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
          end else begin
            work  <= (op_q == OP_SLL) ? (work << 1) : (work >> 1);
            count <= count - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B;
  logic [4:0]  shamt;
  logic        busy, done, Zero, Overflow, Illegal;
  logic [31:0] ALUResult;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: true signed arithmetic decides overflow; shifts are whole-word.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] r, output logic o,
                       output logic il, output int lat);
    longint sa, sb, t;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; o = 1'b0; il = 1'b0; lat = 2;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a | b);
      4'd3: begin t = sa + sb; r = t[31:0]; o = (t > SMAX) || (t < SMIN); end
      4'd4: begin t = sa - sb; r = t[31:0]; o = (t > SMAX) || (t < SMIN); end
      4'd5: begin r = b << sh; lat = int'(sh) + 2; end
      4'd6: begin r = b >> sh; lat = int'(sh) + 2; end
      4'd7: r = {b[15:0], 16'h0000};
      default: il = 1'b1;
    endcase
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int poke,
                        input logic [31:0] exp_res, input logic exp_ovf,
                        input logic exp_ill, input int exp_lat);
    int cyc;
    bit seen, busy_bad;
    @(negedge clk);
    start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
    @(posedge clk);
    cyc = 0; seen = 0; busy_bad = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_bad = 1;
      if (done === 1'b1) seen = 1;
      // Scramble inputs so a late sample would corrupt the result.
      start        = (cyc == poke);
      ALUOperation = (cyc == poke) ? 4'h0 : 4'($urandom);
      A            = $urandom;
      B            = $urandom;
      shamt        = 5'($urandom);
    end
    check({name, ":done_seen"}, 32'(seen), 32'd1);
    check({name, ":latency"}, 32'(cyc), 32'(exp_lat));
    check({name, ":busy"}, 32'(busy_bad), 32'd0);
    check({name, ":result"}, ALUResult, exp_res);
    check({name, ":zero"}, 32'(Zero), 32'(exp_res == 32'd0));
    check({name, ":overflow"}, 32'(Overflow), 32'(exp_ovf));
    check({name, ":illegal"}, 32'(Illegal), 32'(exp_ill));
    @(negedge clk);
    start = 1'b0;
    check({name, ":post_done"}, 32'(done), 32'd0);
    check({name, ":post_busy"}, 32'(busy), 32'd0);
    check({name, ":hold"}, ALUResult, exp_res);
  endtask

  logic [31:0] m_res, r_a, r_b;
  logic        m_ovf, m_ill;
  logic [3:0]  r_op;
  logic [4:0]  r_sh;
  int          m_lat;
  bit          done_in_reset;

  initial begin
    tbl[0]  = '{4'h3, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1, 1'b0};
    tbl[1]  = '{4'h4, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
    tbl[2]  = '{4'h6, 32'h0000_0000, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 1'b0};
    tbl[3]  = '{4'h6, 32'h0000_0000, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[4]  = '{4'h9, 32'h0000_0123, 32'h0000_0456, 5'd3,  32'h0000_0000, 1'b0, 1'b1};
    tbl[5]  = '{4'h7, 32'h0000_0000, 32'h0000_1234, 5'd0,  32'h1234_0000, 1'b0, 1'b0};
    tbl[6]  = '{4'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0,  32'h0F00_0F00, 1'b0, 1'b0};
    tbl[7]  = '{4'h1, 32'h0000_00F0, 32'h0000_000F, 5'd0,  32'h0000_00FF, 1'b0, 1'b0};
    tbl[8]  = '{4'h2, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[9]  = '{4'h4, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0};
    tbl[10] = '{4'h3, 32'h8000_0000, 32'h8000_0000, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    tbl[11] = '{4'h3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
    tbl[12] = '{4'h5, 32'h0000_0000, 32'h0000_0003, 5'd1,  32'h0000_0006, 1'b0, 1'b0};
    tbl[13] = '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b0, 1'b1};
    tbl[14] = '{4'h4, 32'h0000_0001, 32'h8000_0000, 5'd0,  32'h8000_0001, 1'b1, 1'b0};
    tbl[15] = '{4'h7, 32'h0000_0000, 32'hFFFF_ABCD, 5'd0,  32'hABCD_0000, 1'b0, 1'b0};

    reset = 1'b0; start = 1'b0; ALUOperation = '0; A = '0; B = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:result", ALUResult, 32'd0);
    check("rst:zero", 32'(Zero), 32'd1);
    check("rst:overflow", 32'(Overflow), 32'd0);
    check("rst:illegal", 32'(Illegal), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      int lat;
      lat = (tbl[i].op == 4'h5 || tbl[i].op == 4'h6) ? int'(tbl[i].sh) + 2 : 2;
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, -1,
             tbl[i].res, tbl[i].ovf, tbl[i].ill, lat);
    end

    // Long shift with an AND start mid-flight that must be ignored.
    run_op("sll31_busy_start", 4'h5, 32'h0, 32'h0000_0001, 5'd31, 10,
           32'h8000_0000, 1'b0, 1'b0, 33);
    // Start during the done cycle is ignored too.
    run_op("start_in_done", 4'h3, 32'd100, 32'd23, 5'd0, 2, 32'd123, 1'b0, 1'b0, 2);

    // Reset mid-shift aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; ALUOperation = 4'h5; A = '0; B = 32'h0000_0001; shamt = 5'd20;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    check("abort:result", ALUResult, 32'd0);
    check("abort:zero", 32'(Zero), 32'd1);
    done_in_reset = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_in_reset = 1;
    end
    check("abort:quiet", 32'(done_in_reset), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    run_op("after_reset_or", 4'h1, 32'h0000_00F0, 32'h0000_000F, 5'd0, -1,
           32'h0000_00FF, 1'b0, 1'b0, 2);

    for (int i = 0; i < 60; i++) begin
      r_op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      if ($urandom_range(0, 4) == 0) r_b = r_a;
      r_sh = 5'($urandom_range(0, 31));
      model(r_op, r_a, r_b, r_sh, m_res, m_ovf, m_ill, m_lat);
      run_op($sformatf("rand%0d_op%0h", i, r_op), r_op, r_a, r_b, r_sh, -1,
             m_res, m_ovf, m_ill, m_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
